// File: rtl/mult_seq_param.sv
// Parametrised shift-add sequential multiplier.
// Retires BPC multiplier bits per cycle; unsigned or two's-complement operands.
module mult_seq_param #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               signed_md,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] o,
    output logic               busy
);
    localparam int N  = WIDTH / BPC;
    localparam int PW = 2 * WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   o_q, o_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            sm_q, sm_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   pp;
    logic            last;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign last      = (iter_q == LAST);

    // Weighted partial product of the current slice; the signed top bit counts negative
    always_comb begin
        pp = '0;
        for (int b = 0; b < BPC; b++) begin
            if (mplier_q[b]) begin
                if (sm_q && last && (b == BPC - 1)) begin
                    pp = pp - (mcand_q << b);
                end else begin
                    pp = pp + (mcand_q << b);
                end
            end
        end
    end

    // Next-state and datapath updates for IDLE -> RUN -> DONE
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        iter_d      = iter_q;
        sm_d        = sm_q;
        acc_d       = acc_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = signed_md ? {{WIDTH{x[WIDTH-1]}}, x}
                                         : {{WIDTH{1'b0}}, x};
                    mplier_d = y;
                    sm_d     = signed_md;
                    acc_d    = '0;
                    iter_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                iter_d   = iter_q + IW'(1);
                if (last) begin
                    o_d         = acc_q + pp;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            iter_q      <= '0;
            sm_q        <= 1'b0;
            acc_q       <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            iter_q      <= iter_d;
            sm_q        <= sm_d;
            acc_q       <= acc_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
